// File: rtl/regfile_copy_initiator.sv
// regfile_copy_initiator: copies LEN words inside a register-file responder over
// latency-insensitive token channels, one read/write step per handshake round.
module regfile_copy_initiator #(
    parameter int width = 32,
    parameter int n     = 5,
    parameter int lenw  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [n-1:0]     START_SRC,
    input  logic [n-1:0]     START_DST,
    input  logic [lenw-1:0]  START_LEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [n-1:0]     READ_REQ_WRITE,
    output logic             READ_REQ_WRITE_VALID,
    input  logic             READ_REQ_WRITE_CONSUMED,
    input  logic [width-1:0] READ_RESP_READ,
    input  logic             READ_RESP_READ_VALID,
    output logic             READ_RESP_READ_CONSUMED,
    output logic             WRITE_EN_WRITE,
    output logic             WRITE_EN_WRITE_VALID,
    input  logic             WRITE_EN_WRITE_CONSUMED,
    output logic [n-1:0]     WRITE_INDEX_WRITE,
    output logic             WRITE_INDEX_WRITE_VALID,
    input  logic             WRITE_INDEX_WRITE_CONSUMED,
    output logic [width-1:0] WRITE_DATA_WRITE,
    output logic             WRITE_DATA_WRITE_VALID,
    input  logic             WRITE_DATA_WRITE_CONSUMED
);
    localparam logic [1:0] IDLE = 2'd0, COPY = 2'd1, FIN = 2'd2;

    logic [1:0]       state;
    logic [n-1:0]     src, dst;
    logic [lenw-1:0]  len, step;
    logic [width-1:0] cap, hold;
    logic             rq_sent, en_sent, ix_sent, dt_sent, rsp_got;
    logic             copy, last, first;
    logic             rq_d, en_d, ix_d, dt_d, rsp_x, rsp_d, step_done;

    assign copy  = state == COPY;
    assign last  = step == len;
    assign first = step == '0;
    assign BUSY  = copy;
    assign DONE  = state == FIN;

    assign READ_REQ_WRITE_VALID    = copy && !rq_sent;
    assign WRITE_EN_WRITE_VALID    = copy && !en_sent;
    assign WRITE_INDEX_WRITE_VALID = copy && !ix_sent;
    assign WRITE_DATA_WRITE_VALID  = copy && !dt_sent;
    assign READ_RESP_READ_CONSUMED = copy && !rsp_got;

    // The final step re-reads SRC only to keep the responder's read/write pairing.
    assign READ_REQ_WRITE    = last ? src : src + step[n-1:0];
    assign WRITE_EN_WRITE    = !first;
    assign WRITE_INDEX_WRITE = first ? '0 : dst + step[n-1:0] + {n{1'b1}};
    assign WRITE_DATA_WRITE  = first ? '0 : hold;

    assign rq_d  = rq_sent || (READ_REQ_WRITE_VALID && READ_REQ_WRITE_CONSUMED);
    assign en_d  = en_sent || (WRITE_EN_WRITE_VALID && WRITE_EN_WRITE_CONSUMED);
    assign ix_d  = ix_sent || (WRITE_INDEX_WRITE_VALID && WRITE_INDEX_WRITE_CONSUMED);
    assign dt_d  = dt_sent || (WRITE_DATA_WRITE_VALID && WRITE_DATA_WRITE_CONSUMED);
    assign rsp_x = READ_RESP_READ_CONSUMED && READ_RESP_READ_VALID;
    assign rsp_d = rsp_got || rsp_x;
    assign step_done = copy && rq_d && en_d && ix_d && dt_d && rsp_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            step    <= '0;
            cap     <= '0;
            hold    <= '0;
            rq_sent <= 1'b0;
            en_sent <= 1'b0;
            ix_sent <= 1'b0;
            dt_sent <= 1'b0;
            rsp_got <= 1'b0;
        end else if (state == IDLE) begin
            if (START) begin
                src   <= START_SRC;
                dst   <= START_DST;
                len   <= START_LEN;
                step  <= '0;
                state <= START_LEN == '0 ? FIN : COPY;
            end
        end else if (state == FIN) begin
            state <= IDLE;
        end else if (step_done) begin
            // hold feeds the next step's write; cap covers a response that arrived early
            if (!last) hold <= rsp_got ? cap : READ_RESP_READ;
            rq_sent <= 1'b0;
            en_sent <= 1'b0;
            ix_sent <= 1'b0;
            dt_sent <= 1'b0;
            rsp_got <= 1'b0;
            step    <= step + lenw'(1);
            if (last) state <= FIN;
        end else begin
            rq_sent <= rq_d;
            en_sent <= en_d;
            ix_sent <= ix_d;
            dt_sent <= dt_d;
            rsp_got <= rsp_d;
            if (rsp_x) cap <= READ_RESP_READ;
        end
    end
endmodule

// File: tb/tb_regfile_copy_initiator.sv
// tb_regfile_copy_initiator: random-stall responder plus a sequential-copy reference model.
module tb_regfile_copy_initiator;
    localparam int W = 32, N = 5, L = 6, SZ = 32;

    logic CLK = 1'b0, RST = 1'b1, START = 1'b0;
    logic [N-1:0] START_SRC = '0, START_DST = '0;
    logic [L-1:0] START_LEN = '0;
    logic BUSY, DONE;
    logic [N-1:0] READ_REQ_WRITE, WRITE_INDEX_WRITE;
    logic READ_REQ_WRITE_VALID, READ_RESP_READ_CONSUMED, WRITE_EN_WRITE, WRITE_EN_WRITE_VALID;
    logic WRITE_INDEX_WRITE_VALID, WRITE_DATA_WRITE_VALID;
    logic [W-1:0] WRITE_DATA_WRITE, rsp_d;
    logic rq_c = 1'b1, en_c = 1'b1, ix_c = 1'b1, dt_c = 1'b1, rsp_go = 1'b1, rsp_v;

    regfile_copy_initiator #(.width(W), .n(N), .lenw(L)) dut (
        .CLK(CLK), .RST(RST), .START(START), .START_SRC(START_SRC), .START_DST(START_DST),
        .START_LEN(START_LEN), .BUSY(BUSY), .DONE(DONE),
        .READ_REQ_WRITE(READ_REQ_WRITE), .READ_REQ_WRITE_VALID(READ_REQ_WRITE_VALID),
        .READ_REQ_WRITE_CONSUMED(rq_c),
        .READ_RESP_READ(rsp_d), .READ_RESP_READ_VALID(rsp_v),
        .READ_RESP_READ_CONSUMED(READ_RESP_READ_CONSUMED),
        .WRITE_EN_WRITE(WRITE_EN_WRITE), .WRITE_EN_WRITE_VALID(WRITE_EN_WRITE_VALID),
        .WRITE_EN_WRITE_CONSUMED(en_c),
        .WRITE_INDEX_WRITE(WRITE_INDEX_WRITE), .WRITE_INDEX_WRITE_VALID(WRITE_INDEX_WRITE_VALID),
        .WRITE_INDEX_WRITE_CONSUMED(ix_c),
        .WRITE_DATA_WRITE(WRITE_DATA_WRITE), .WRITE_DATA_WRITE_VALID(WRITE_DATA_WRITE_VALID),
        .WRITE_DATA_WRITE_CONSUMED(dt_c)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // responder: register array, per-step token collection, same-step write forwarding
    logic [W-1:0] arr [SZ];
    logic [W-1:0] pat [SZ];
    logic load = 1'b0;
    logic g_rq = 0, g_en = 0, g_ix = 0, g_dt = 0;
    logic [N-1:0] s_rq = '0, s_ix = '0, e_rq, e_ix;
    logic s_en = 1'b0, e_en, all_in;
    logic [W-1:0] s_dt = '0, e_dt;
    int stall = 0, rstall = 0;

    always_comb begin
        e_rq = g_rq ? s_rq : READ_REQ_WRITE;
        e_en = g_en ? s_en : WRITE_EN_WRITE;
        e_ix = g_ix ? s_ix : WRITE_INDEX_WRITE;
        e_dt = g_dt ? s_dt : WRITE_DATA_WRITE;
        all_in = (g_rq || (READ_REQ_WRITE_VALID && rq_c)) && (g_en || (WRITE_EN_WRITE_VALID && en_c))
              && (g_ix || (WRITE_INDEX_WRITE_VALID && ix_c)) && (g_dt || (WRITE_DATA_WRITE_VALID && dt_c));
        rsp_v = rsp_go && all_in;
        rsp_d = (e_en && e_ix == e_rq) ? e_dt : arr[e_rq];
    end

    // reference model: a copy is a plain forward loop over the array
    logic active = 0, done_due = 0, run_chk = 0, busy_seen = 0;
    int step = 0, m_len = 0, en0_cnt = 0;
    logic [N-1:0] m_src = '0, m_dst = '0;
    logic [W-1:0] vals [33];
    logic [W-1:0] exp_arr [SZ];
    logic [W-1:0] t [SZ];
    logic [N+W-1:0] wlog [$];

    always @(posedge CLK) begin
        if (load) arr <= pat;
        if (RST) begin
            {g_rq, g_en, g_ix, g_dt} <= '0;
            active <= 0;
            done_due <= 0;
        end else begin
            done_due <= 0;
            if (READ_REQ_WRITE_VALID && rq_c) begin chk("dup_rq", g_rq, 0); g_rq <= 1; s_rq <= READ_REQ_WRITE; end
            if (WRITE_EN_WRITE_VALID && en_c) begin chk("dup_en", g_en, 0); g_en <= 1; s_en <= WRITE_EN_WRITE; end
            if (WRITE_INDEX_WRITE_VALID && ix_c) begin chk("dup_ix", g_ix, 0); g_ix <= 1; s_ix <= WRITE_INDEX_WRITE; end
            if (WRITE_DATA_WRITE_VALID && dt_c) begin chk("dup_dt", g_dt, 0); g_dt <= 1; s_dt <= WRITE_DATA_WRITE; end
            if (rsp_v && READ_RESP_READ_CONSUMED) begin
                if (e_en) begin arr[e_ix] <= e_dt; wlog.push_back({e_ix, e_dt}); end
                else en0_cnt++;
                {g_rq, g_en, g_ix, g_dt} <= '0;
                if (step == m_len) begin active <= 0; done_due <= 1; end
                step <= step + 1;
            end
            if (START && !active && !done_due) begin
                m_src <= START_SRC;
                m_dst <= START_DST;
                m_len <= int'(START_LEN);
                step <= 0;
                if (START_LEN == 0) done_due <= 1; else active <= 1;
                for (int k = 0; k < SZ; k++) t[k] = arr[k];
                for (int k = 0; k < int'(START_LEN); k++) begin
                    vals[k] = t[(int'(START_SRC) + k) % SZ];
                    t[(int'(START_DST) + k) % SZ] = vals[k];
                end
                exp_arr = t;
            end
        end
    end

    always @(negedge CLK) begin
        if (run_chk) begin
            if (active) begin
                busy_seen |= BUSY;
                chk("busy", BUSY, 1);
                chk("done_lo", DONE, 0);
                chk("rsp_cons", READ_RESP_READ_CONSUMED, 1);
                chk("rq_valid", READ_REQ_WRITE_VALID, !g_rq);
                chk("en_valid", WRITE_EN_WRITE_VALID, !g_en);
                chk("ix_valid", WRITE_INDEX_WRITE_VALID, !g_ix);
                chk("dt_valid", WRITE_DATA_WRITE_VALID, !g_dt);
                if (READ_REQ_WRITE_VALID)
                    chk("rq_tok", READ_REQ_WRITE, step < m_len ? (int'(m_src) + step) % SZ : int'(m_src));
                if (WRITE_EN_WRITE_VALID) chk("en_tok", WRITE_EN_WRITE, step > 0);
                if (WRITE_INDEX_WRITE_VALID)
                    chk("ix_tok", WRITE_INDEX_WRITE, step > 0 ? (int'(m_dst) + step - 1) % SZ : 0);
                if (WRITE_DATA_WRITE_VALID) chk("dt_tok", WRITE_DATA_WRITE, step > 0 ? vals[step-1] : 0);
            end else begin
                busy_seen |= BUSY;
                chk("done", DONE, done_due);
                chk("busy_idle", BUSY, 0);
                chk("idle_valids", {READ_REQ_WRITE_VALID, WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID,
                                    WRITE_DATA_WRITE_VALID, READ_RESP_READ_CONSUMED}, 0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        rq_c = $urandom_range(99) >= stall;
        en_c = $urandom_range(99) >= stall;
        ix_c = $urandom_range(99) >= stall;
        dt_c = $urandom_range(99) >= stall;
        rsp_go = $urandom_range(99) >= rstall;
    endtask

    task automatic load_pat();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run_copy(input int src, input int dst, input int len, input bit poke, output int cyc);
        int mism;
        wlog.delete();
        en0_cnt = 0;
        START_SRC = N'(src);
        START_DST = N'(dst);
        START_LEN = L'(len);
        START = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) START = 1'b0;
            if (poke && cyc == 2) begin START = 1'b1; START_SRC = 7; START_LEN = 5; end
            if (poke && cyc == 3) START = 1'b0;
        end while (DONE !== 1'b1 && cyc < 3000);
        chk("done_seen", DONE, 1);
        tick();
        mism = 0;
        for (int k = 0; k < SZ; k++) if (arr[k] !== exp_arr[k]) mism++;
        chk("arr_model", mism, 0);
    endtask

    logic [W-1:0] snap [SZ];
    logic [W-1:0] r1 [SZ];

    initial begin
        int cyc, mism;
        repeat (3) tick();
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_valids", {READ_REQ_WRITE_VALID, WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID,
                           WRITE_DATA_WRITE_VALID, READ_RESP_READ_CONSUMED}, 0);
        RST = 1'b0;
        run_chk = 1'b1;

        // basic copy, always-ready responder
        for (int k = 0; k < SZ; k++) pat[k] = W'(k);
        load_pat();
        run_copy(2, 10, 3, 0, cyc);
        chk("t1_latency", cyc, 5);
        chk("t1_nwrites", wlog.size(), 3);
        chk("t1_en0", en0_cnt, 1);
        if (wlog.size() == 3) begin
            chk("t1_w0", wlog[0], {5'd10, 32'd2});
            chk("t1_w1", wlog[1], {5'd11, 32'd3});
            chk("t1_w2", wlog[2], {5'd12, 32'd4});
        end
        mism = 0;
        for (int k = 0; k < SZ; k++) if (arr[k] !== ((k >= 10 && k <= 12) ? W'(k - 8) : W'(k))) mism++;
        chk("t1_arr", mism, 0);

        // zero length
        busy_seen = 0;
        run_copy(5, 7, 0, 0, cyc);
        chk("t2_latency", cyc, 1);
        chk("t2_busy_never", busy_seen, 0);
        chk("t2_tokens", wlog.size() + en0_cnt, 0);

        // stalls versus clean run from the same start
        for (int k = 0; k < SZ; k++) begin pat[k] = $urandom; snap[k] = pat[k]; end
        load_pat();
        stall = 30; rstall = 50;
        run_copy(3, 20, 8, 0, cyc);
        r1 = arr;
        pat = snap;
        load_pat();
        stall = 0; rstall = 0;
        run_copy(3, 20, 8, 0, cyc);
        mism = 0;
        for (int k = 0; k < SZ; k++) if (arr[k] !== r1[k]) mism++;
        chk("t3_stall_vs_clean", mism, 0);

        // overlapping forward copy
        for (int k = 0; k < SZ; k++) pat[k] = W'(k + 100);
        load_pat();
        run_copy(0, 1, 4, 0, cyc);
        for (int k = 0; k <= 4; k++) chk("t4_overlap", arr[k], 100);
        chk("t4_untouched", arr[5], 105);

        // index wrap plus an ignored START mid-copy
        load_pat();
        stall = 20;
        run_copy(30, 0, 4, 1, cyc);
        chk("t5_a0", arr[0], 130);
        chk("t5_a1", arr[1], 131);
        chk("t5_a2", arr[2], 130);
        chk("t5_a3", arr[3], 131);
        chk("t5_a4", arr[4], 104);
        stall = 0;

        // reset during step 2
        for (int k = 0; k < SZ; k++) pat[k] = W'(k * 3);
        load_pat();
        START_SRC = 4; START_DST = 12; START_LEN = 6; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t6_busy", BUSY, 0);
        chk("t6_done", DONE, 0);
        chk("t6_valids", {READ_REQ_WRITE_VALID, WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID,
                          WRITE_DATA_WRITE_VALID}, 0);
        repeat (4) tick();
        chk("t6_step1_written", arr[12], 12);
        chk("t6_step2_abandoned", arr[13], 39);
        run_copy(1, 2, 6, 0, cyc);
        chk("t6_restart_latency", cyc, 8);

        // full-range copy then random copies
        for (int k = 0; k < SZ; k++) pat[k] = $urandom;
        load_pat();
        run_copy(9, 17, 32, 0, cyc);
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < SZ; k++) pat[k] = $urandom;
            load_pat();
            stall = $urandom_range(40);
            rstall = $urandom_range(40);
            run_copy($urandom_range(31), $urandom_range(31), $urandom_range(32), 0, cyc);
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/regfile_copy_initiator.md
Name: regfile_copy_initiator

Overview:
- Initiator/client end of the latency-insensitive register-file port protocol. Each channel is a WRITE/VALID/CONSUMED triple.
- The block drives the read-request channel and the three write channels, and consumes the read-response channel.
- On a START command it copies LEN words from index SRC.. to index DST.. of an attached register-file responder.
- It sits between a control unit and any responder with READ_REQ/READ_RESP/WRITE_EN/WRITE_INDEX/WRITE_DATA channels.

Parameters:
width, 32, data word width
n, 5, index width; indices wrap modulo 2^n
lenw, 6, length field width (n+1, so a full 2^n copy is expressible)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
START  in  1  command strobe, sampled only in IDLE
START_SRC  in  n  first source index
START_DST  in  n  first destination index
START_LEN  in  lenw  word count
BUSY  out  1  high from accepted START until DONE
DONE  out  1  one-cycle pulse when the copy completes
READ_REQ_WRITE  out  n  read index token
READ_REQ_WRITE_VALID  out  1  read token present
READ_REQ_WRITE_CONSUMED  in  1  responder took read token
READ_RESP_READ  in  width  read data
READ_RESP_READ_VALID  in  1  read data present
READ_RESP_READ_CONSUMED  out  1  initiator takes read data
WRITE_EN_WRITE  out  1  write enable token
WRITE_EN_WRITE_VALID  out  1  write-enable token present
WRITE_EN_WRITE_CONSUMED  in  1  write-enable token taken
WRITE_INDEX_WRITE  out  n  write index token
WRITE_INDEX_WRITE_VALID  out  1  write-index token present
WRITE_INDEX_WRITE_CONSUMED  in  1  write-index token taken
WRITE_DATA_WRITE  out  width  write data token
WRITE_DATA_WRITE_VALID  out  1  write-data token present
WRITE_DATA_WRITE_CONSUMED  in  1  write-data token taken

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset (RST high at an edge): state=IDLE; all *_VALID=0; READ_RESP_READ_CONSUMED=0; BUSY=0; DONE=0; counters, flags and capture register cleared.
- Reset mid-copy: the copy is abandoned immediately; no further tokens are issued; no DONE pulse.
- Token transfer rule: a token transfers at an edge where its VALID=1 and CONSUMED=1.
  - After a transfer, that channel's VALID drops and stays low until the next step.
  - While VALID=1, the token value is held stable.
  - Each channel is tracked independently by a per-step "sent" flag.
- Response transfer rule: a response transfers at an edge where READ_RESP_READ_VALID=1 and READ_RESP_READ_CONSUMED=1.
  - READ_RESP_READ_CONSUMED = in a read-carrying step and response not yet taken (independent of VALID).
  - The transferred data is captured into the hold register.
- A step is complete at the edge where all four output tokens and, when required, the response have transferred, counting transfers at that same edge. The next step's tokens go VALID in the following cycle.
- Steps, with i = step number 0..LEN:
  - Read request (i<LEN): READ_REQ=SRC+i mod 2^n; the response is required.
  - Read request (i=LEN): READ_REQ=SRC; the response is required and its data is discarded. This keeps the responder's per-step token pairing.
  - Write (i>0): WRITE_EN=1, WRITE_INDEX=DST+i-1 mod 2^n, WRITE_DATA=hold register (the data read in step i-1).
  - Write (i=0): WRITE_EN=0, WRITE_INDEX=0, WRITE_DATA=0.
  - Write tokens are issued every step because the responder only advances on write tokens.
- State machine:
  - IDLE: START=1 and LEN>0 → COPY (latch SRC, DST, LEN; i=0; BUSY=1 next cycle).
  - IDLE: START=1 and LEN=0 → DONE with no tokens issued.
  - COPY: step complete with i=LEN → DONE; otherwise increment i.
  - DONE: DONE=1 for exactly one cycle, BUSY=0 → IDLE.
  - START outside IDLE is ignored.
- Totals: LEN+1 steps; LEN read requests plus one dummy; LEN writes with en=1.
- Overlap: the responder forwards the pending write to a same-index read. The result therefore equals a sequential forward copy (word k read after word k-1 is written), including overlapping ranges with DST>SRC.
- Minimum latency with a responder that always consumes: one step per cycle; DONE pulses LEN+2 cycles after the START edge.
- Index arithmetic wraps modulo 2^n. LEN=2^n is legal and covers every index exactly once.

Test Plan:
- Always-ready responder, arr[i]=i, START SRC=2 DST=10 LEN=3 → writes (10,2),(11,3),(12,4), each with en=1, preceded by one en=0 token. DONE pulses 5 cycles after START. Final arr[10..12]=2,3,4 and nothing else changes.
- LEN=0 → DONE pulses next cycle; no VALID is ever asserted; BUSY never rises.
- Random per-channel CONSUMED stalls (30% duty each) plus a delayed RESP_VALID, LEN=8 → identical final array to the no-stall run. Every token is stable while VALID=1, and no token transfers twice per step.
- Overlap SRC=0 DST=1 LEN=4, arr[i]=i+100 → arr[1..4]=100,100,100,100 (forward-copy semantics).
- Wrap with n=5: SRC=30 DST=0 LEN=4 → reads 30,31,0,1 and writes indices 0..3 with the sequential-copy values. START asserted mid-copy is ignored.
- RST high during step 2 of LEN=6 → next cycle all VALID=0, BUSY=0, no DONE. A fresh START then completes normally.
